alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Two-requester front end for the shared N-bit `alu` datapath.
- Round-robin arbitrates between the requesters, latches the granted operation and sequences execution.
- Single-cycle ALU ops execute in one EXEC cycle. A multi-cycle shift-add multiply covers the ALU's missing multiplier.
- Returns a registered result to the originating requester with a one-cycle response pulse.

Parameters:
- N, 8: operand/result width; passed to the `alu` instance and the multiplier.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle when valid & ready
- req0_op  in  4  opcode: 0..7 as ALU (add, sub, and, or, xor, sll, srl, sra); 8 = mul; 9..15 reserved
- req0_a, req0_b  in  N  operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0
- rsp0_valid  out  1  one-cycle pulse: result for requester 0
- rsp1_valid  out  1  one-cycle pulse: result for requester 1
- rsp_y  out  N  result, low half for mul
- rsp_hi  out  N  high half of product for mul; 0 otherwise
- rsp_flg  out  1  flag

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE; rr pointer = 1, so requester 0 wins first.
  - All outputs 0; latched op/operands 0.
  - rst dominates every other event, including mid-EXEC or mid-MUL: the in-flight op is dropped with no response.
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - reqX_ready = grant_X, combinational.
  - grant: if only one requester is valid, grant it. If both are valid, grant the one not named by the rr pointer.
  - On handshake at cycle T: latch op, a, b and the requester id; set rr pointer = granted id.
  - Go to MUL if op == 8, else EXEC.
- ready is 0 in every state except IDLE.
- EXEC (cycle T+1):
  - `alu` sees the latched op/a/b.
  - Register rsp_y = alu.y, rsp_flg = alu.flg, rsp_hi = 0.
  - Ops 9..15: force rsp_y = 0, rsp_flg = 0.
  - Go to RESP.
- MUL (cycles T+1..T+N):
  - One shift-add step per cycle on an unsigned 2N-bit accumulator.
  - After the Nth step: rsp_y = product[N-1:0], rsp_hi = product[2N-1:N], rsp_flg = (rsp_hi != 0).
  - Go to RESP.
- RESP:
  - Pulse rsp<id>_valid for exactly one cycle.
  - rsp_y/rsp_hi/rsp_flg hold their values until the next result is registered.
  - Go to IDLE.
- Latency from handshake cycle T to the response pulse: T+2 for single-cycle ops, T+N+1 for mul.
- Throughput: at most one accepted op per 3 cycles for single-cycle ops.
- Arithmetic wraps modulo 2^N for add/sub; shift amounts are as the ALU defines them.
- No response backpressure: requesters must accept the response pulse when it is asserted.
- valid held while not granted: op stays pending, and it wins the next arbitration if the other requester was the last one granted.

Optional Feature:
- Macro ALU_SCHED_PERF_EN.
- Defined: adds output ports perf_ops0, perf_ops1 (16 bits, saturating at 0xFFFF, reset to 0). Each increments on its requester's handshake.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - opcode enum: OP_ADD=0 .. OP_SRA=7, OP_MUL=8
  - state enum
  - constant REQ_CNT=2
- Sub-module seq_mul #(N): start/done iterative shift-add multiplier. alu_sched instantiates it alongside `alu`.

Test Plan (N=8):
- Reset, then idle → all outputs 0. First cycle with both valid → req0_ready=1, req1_ready=0.
- req0 add a=0x7F b=0x01, handshake at T → rsp0_valid at T+2, rsp_y=0x80, rsp_hi=0x00.
- req0 sub a=5 b=3 and req1 xor a=0xF0 b=0xFF, both valid at T:
  - req0 served first: rsp0_valid at T+2, rsp_y=0x02.
  - req1 handshake at T+3: rsp1_valid at T+5, rsp_y=0x0F.
- req1 mul a=0xFF b=0xFF at T → rsp1_valid at T+9, rsp_y=0x01, rsp_hi=0xFE, rsp_flg=1.
- mul 0x0F*0x03, rst pulsed at T+4 → no response pulse ever. After rst, IDLE, and req0 wins the next contested grant.
- req0 op=15 at T → rsp0_valid at T+2, rsp_y=0, rsp_flg=0. req0 sll a=0x01 b=3 → rsp_y=0x08.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, scheduler states and shared constants for alu_sched.
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_MUL
  } op_e;
  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_e;
  localparam int REQ_CNT = 2;
  function automatic logic is_rsvd(input logic [3:0] op);
    return op > OP_MUL;
  endfunction
endpackage

// File: rtl/alu.sv
// alu: shared single-cycle N-bit datapath; flg is the zero flag of y.
module alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y,
  output logic         flg
);
  localparam int SW = $clog2(N);
  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];
  always_comb begin
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << sh;
      OP_SRL:  y = a >> sh;
      OP_SRA:  y = $signed(a) >>> sh;
      default: y = '0;
    endcase
  end
  assign flg = y == '0;
endmodule

// File: rtl/seq_mul.sv
// seq_mul: iterative unsigned shift-add multiplier, one step per cycle, N steps per start.
module seq_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] prod
);
  localparam int CW = $clog2(N + 1);
  logic [2*N-1:0] p;
  logic [N-1:0]   mc;
  logic [CW-1:0]  cnt;
  logic [N:0]     sum;
  // prod is the value after the current step, so it is final in the cycle done is high
  assign sum  = {1'b0, p[2*N-1:N]} + (p[0] ? {1'b0, mc} : '0);
  assign prod = {sum, p[N-1:1]};
  assign done = cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      p   <= '0;
      mc  <= '0;
      cnt <= '0;
    end else if (start) begin
      p   <= {{N{1'b0}}, b};
      mc  <= a;
      cnt <= CW'(N);
    end else if (cnt != '0) begin
      p   <= prod;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin two-requester front end for alu plus seq_mul.
// ALU_SCHED_PERF_EN adds saturating per-requester handshake counters.
module alu_sched
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [N-1:0] rsp_y,
  output logic [N-1:0] rsp_hi,
  output logic         rsp_flg
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [15:0]  perf_ops0,
  output logic [15:0]  perf_ops1
`endif
);
  state_e             state;
  logic               rr, id, hs, alu_flg, mul_done;
  logic [REQ_CNT-1:0] grant;
  logic [3:0]         op, nop;
  logic [N-1:0]       a, b, na, nb, alu_y;
  logic [2*N-1:0]     prod;
  // rr names the last winner; on contention the other requester is granted
  assign grant[0]   = state == IDLE && req0_valid && (!req1_valid || rr);
  assign grant[1]   = state == IDLE && req1_valid && (!req0_valid || !rr);
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign hs  = |grant;
  assign nop = grant[1] ? req1_op : req0_op;
  assign na  = grant[1] ? req1_a : req0_a;
  assign nb  = grant[1] ? req1_b : req0_b;
  alu #(.N(N)) u_alu (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (alu_y),
    .flg(alu_flg)
  );
  // multiplier loads straight from the request so its N steps fill MUL exactly
  seq_mul #(.N(N)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(hs && nop == OP_MUL),
    .a    (na),
    .b    (nb),
    .done (mul_done),
    .prod (prod)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= 1'b1;
      id         <= 1'b0;
      op         <= '0;
      a          <= '0;
      b          <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_y      <= '0;
      rsp_hi     <= '0;
      rsp_flg    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          op    <= nop;
          a     <= na;
          b     <= nb;
          id    <= grant[1];
          rr    <= grant[1];
          state <= nop == OP_MUL ? MUL : EXEC;
        end
        EXEC: begin
          rsp_y      <= is_rsvd(op) ? '0 : alu_y;
          rsp_flg    <= !is_rsvd(op) && alu_flg;
          rsp_hi     <= '0;
          rsp0_valid <= !id;
          rsp1_valid <= id;
          state      <= RESP;
        end
        MUL: if (mul_done) begin
          rsp_y      <= prod[N-1:0];
          rsp_hi     <= prod[2*N-1:N];
          rsp_flg    <= |prod[2*N-1:N];
          rsp0_valid <= !id;
          rsp1_valid <= id;
          state      <= RESP;
        end
        RESP: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALU_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops0 <= '0;
      perf_ops1 <= '0;
    end else begin
      if (grant[0] && perf_ops0 != '1) perf_ops0 <= perf_ops0 + 1'b1;
      if (grant[1] && perf_ops1 != '1) perf_ops1 <= perf_ops1 + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed and random ops against a behavioural model of alu_sched.
module tb_alu_sched;
  logic       clk = 0, rst = 1;
  logic       req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0] req0_op = 0, req1_op = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic       rsp0_valid, rsp1_valid, rsp_flg;
  logic [7:0] rsp_y, rsp_hi;
  int         total = 0, bad = 0, cyc = 0, pulses;
  bit         m_rr;
  logic [1:0] sel;
  logic [3:0] ro0, ro1;

  alu_sched #(.N(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_y(rsp_y), .rsp_hi(rsp_hi), .rsp_flg(rsp_flg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input logic [3:0] o, input logic [7:0] a, b,
                                 output logic [7:0] y, h, output logic f);
    int sh = int'(b) % 8;
    logic [15:0] p = 16'(a) * 16'(b);
    y = 0;
    h = 0;
    case (o)
      0: y = a + b;
      1: y = a - b;
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = a << sh;
      6: y = a >> sh;
      7: y = $signed(a) >>> sh;
      8: begin y = p[7:0]; h = p[15:8]; end
      default: y = 0;
    endcase
    f = (o == 8) ? (h != 0) : (o < 8 ? (y == 0) : 1'b0);
  endfunction

  task automatic go(input bit v0, input logic [3:0] o0, input logic [7:0] a0, b0,
                    input bit v1, input logic [3:0] o1, input logic [7:0] a1, b1);
    bit p0, p1, w, seen;
    int t0;
    logic [3:0] eo;
    logic [7:0] ea, eb, ey, eh;
    logic ef;
    p0 = v0;
    p1 = v1;
    @(negedge clk);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    #1;
    while (p0 || p1) begin
      w = (p0 && p1) ? !m_rr : p1;
      chk("grant", {req0_ready, req1_ready}, w ? 2'b01 : 2'b10);
      eo = w ? o1 : o0;
      ea = w ? a1 : a0;
      eb = w ? b1 : b0;
      ref_op(eo, ea, eb, ey, eh, ef);
      m_rr = w;
      t0 = cyc;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (k == 0) begin
          if (w) begin req1_valid = 0; p1 = 0; end
          else begin req0_valid = 0; p0 = 0; end
        end
        #1;
        if (rsp0_valid || rsp1_valid) begin
          seen = 1;
          chk("rsp_id", {rsp0_valid, rsp1_valid}, w ? 2'b01 : 2'b10);
          chk("latency", cyc - t0, eo == 4'd8 ? 9 : 2);
          chk("rsp_y", rsp_y, ey);
          chk("rsp_hi", rsp_hi, eh);
          chk("rsp_flg", rsp_flg, ef);
        end else chk("busy_ready", {req0_ready, req1_ready}, 0);
      end
      if (!seen) chk("rsp_timeout", 0, 1);
      @(negedge clk);
      #1;
      chk("rsp_end", {rsp0_valid, rsp1_valid}, 0);
      chk("rsp_hold", {rsp_y, rsp_hi, 7'b0, rsp_flg}, {ey, eh, 7'b0, ef});
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    m_rr = 1;
    #1;
    chk("reset_out", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y, rsp_hi, rsp_flg}, 0);
    go(1, 4'd0, 8'h7F, 8'h01, 0, 4'd0, 8'h00, 8'h00);
    go(0, 4'd0, 8'h00, 8'h00, 1, 4'd8, 8'hFF, 8'hFF);
    go(1, 4'd1, 8'h05, 8'h03, 1, 4'd4, 8'hF0, 8'hFF);
    go(1, 4'd15, 8'h12, 8'h34, 0, 4'd0, 8'h00, 8'h00);
    go(1, 4'd5, 8'h01, 8'h03, 0, 4'd0, 8'h00, 8'h00);
    // mul interrupted by reset four cycles after its handshake
    @(negedge clk);
    req0_valid = 1; req0_op = 4'd8; req0_a = 8'h0F; req0_b = 8'h03;
    #1;
    chk("mul_ready", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_rr = 1;
    #1;
    chk("rst_mid_mul", {rsp0_valid, rsp1_valid, rsp_y, rsp_hi, rsp_flg}, 0);
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      #1;
      if (rsp0_valid || rsp1_valid) pulses++;
    end
    chk("no_rsp_after_rst", pulses, 0);
    go(1, 4'd2, 8'hCC, 8'hAA, 1, 4'd3, 8'h11, 8'h22);
    repeat (60) begin
      sel = 2'($urandom_range(1, 3));
      ro0 = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      ro1 = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      go(sel[0], ro0, 8'($urandom), 8'($urandom), sel[1], ro1, 8'($urandom), 8'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
